// File: rtl/pc_npc_fetch_unit.sv
// pc_npc_fetch_unit: PC/nPC fetch sequencer with SPARC delayed transfer.
// Ports: Clk,R,LE | ID_* decisions/target | PC_Out,nPC_Out,ID_annul,fetch_count.
module pc_npc_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              LE,
  input  logic              ID_B_instr,
  input  logic              ID_ba,
  input  logic              ID_cond_true,
  input  logic              ID_29_a,
  input  logic              ID_Call_instr,
  input  logic              ID_jmpl_instr,
  input  logic [ADDR_W-1:0] ID_target,
  output logic [ADDR_W-1:0] PC_Out,
  output logic [ADDR_W-1:0] nPC_Out,
  output logic              ID_annul,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc_q;
  logic [ADDR_W-1:0] npc_d;
  logic [CNT_W-1:0]  cnt_q;

  logic              v;
  logic              take;
  logic              annul_next;
  logic [ADDR_W-1:0] tgt_aligned;
  logic              unused_tgt;

  // Instruction in an annulled slot must not steer fetch.
  assign v = (state_q == RUN);

  assign take = v & (ID_Call_instr | ID_jmpl_instr |
                     (ID_B_instr & (ID_cond_true | ID_ba)));

  // Taken conditional with a=1 keeps its slot; ba,a or untaken,a squash it.
  assign annul_next = v & ID_B_instr & ID_29_a &
                      (~ID_cond_true | ID_ba);

  assign tgt_aligned = {ID_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt  = ^ID_target[1:0];

  assign npc_d = take ? tgt_aligned : npc_q + ADDR_W'(4);

  always_ff @(posedge Clk) begin
    if (R) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + ADDR_W'(4);
      cnt_q   <= '0;
    end else if (LE) begin
      state_q <= state_d;
      pc_q    <= npc_q;
      npc_q   <= npc_d;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (annul_next) state_d = SQUASH;
      SQUASH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    PC_Out      = pc_q;
    nPC_Out     = npc_q;
    ID_annul    = (state_q == SQUASH);
    fetch_count = cnt_q;
  end

endmodule

// File: doc/pc_npc_fetch_unit.md
# pc_npc_fetch_unit

Fetch-stage sequencer that replaces the separate PC, nPC and +4 adder with one block implementing SPARC-style delayed control transfer. It drives the instruction-memory address and the IF/ID register. It consumes the branch/call/jmpl decisions produced by the ID-stage control unit, and flags annulled delay-slot instructions so the control-signal mux can squash them.

## Interface
Parameters:
- ADDR_W, 32, width of PC, nPC, target and increment arithmetic
- RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+4
- CNT_W, 16, width of the fetch counter

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- R  in  1  reset, synchronous, active-high
- LE  in  1  load enable; 0 = stall, all state holds
- ID_B_instr  in  1  instruction in ID is a conditional/unconditional branch
- ID_ba  in  1  branch in ID is branch-always (cond field 1000)
- ID_cond_true  in  1  branch condition evaluated true (ignored unless ID_B_instr)
- ID_29_a  in  1  annul bit of branch in ID
- ID_Call_instr  in  1  instruction in ID is call
- ID_jmpl_instr  in  1  instruction in ID is jmpl
- ID_target  in  ADDR_W  resolved transfer target for the ID instruction
- PC_Out  out  ADDR_W  current fetch address to instruction memory
- nPC_Out  out  ADDR_W  next PC
- ID_annul  out  1  instruction currently in ID is annulled; forces mux select to NOP
- fetch_count  out  CNT_W  number of non-stalled fetch advances since reset

## Operation
- Clocking: one clock, Clk; R synchronous active-high. R has priority over LE.
- Reset edge: PC_Out=RESET_PC, nPC_Out=RESET_PC+4, ID_annul=0, fetch_count=0.
- Qualify: v = ~ID_annul. All ID inputs are ignored when ID_annul=1; that instruction is squashed.
- take = v & (ID_Call_instr | ID_jmpl_instr | (ID_B_instr & (ID_cond_true | ID_ba))).
- annul_next = v & ID_B_instr & ID_29_a & (~ID_cond_true | ID_ba). A taken conditional with a=1 keeps its delay slot. Branch-always with a=1 and untaken-with-a=1 squash it.
- Advance edge (R=0, LE=1):
  - PC <= nPC.
  - nPC <= take ? {ID_target[ADDR_W-1:2],2'b00} : nPC+4. Mod 2^ADDR_W; wrap from 0xFFFFFFFC to 0 is legal.
  - ID_annul <= annul_next.
  - fetch_count <= fetch_count+1, wraps at 2^CNT_W.
- Stall edge (R=0, LE=0): PC, nPC, ID_annul and fetch_count hold. The ID instruction is re-presented and re-evaluated next cycle.
- Priority when several transfer flags are set: all produce the same target source (ID_target), so there is no conflict. Simultaneous ID_B_instr and ID_Call_instr is treated as taken.
- Internal state machine: RUN (ID_annul=0) and SQUASH (ID_annul=1).
  - RUN -> SQUASH on an advance edge with annul_next=1.
  - SQUASH -> RUN on any advance edge.
  - SQUASH holds under stall.
  - Any state -> RUN on reset.

## Timing
- All outputs registered; none combinationally depend on inputs.
- Transfer latency: a branch in ID at cycle n redirects nPC at edge n. The delay-slot instruction (already at PC) is fetched in cycle n. The target is fetched in cycle n+1.
- ID_annul is high for exactly one unstalled cycle, aligned with the delay-slot instruction occupying ID.
- Reset mid-stall or mid-SQUASH: the next edge with R=1 restores reset values regardless of LE.
- Back-to-back branches: a branch that sits in the annulled slot has no effect.

## Test plan
- Reset then 4 free-running edges, no transfers -> PC_Out 0,4,8,12,16. fetch_count=4. ID_annul=0 throughout.
- Taken branch, a=0, ID_target=0x40, at PC=8/nPC=12 -> next PC=12, then 0x40, then 0x44. ID_annul stays 0.
- Untaken conditional with a=1 at PC=8 -> PC=12 with ID_annul=1 for one cycle, then PC=16. Call asserted during the annulled cycle is ignored.
- Branch-always with a=1, target 0x80 -> delay slot (PC=12) annulled, then PC=0x80.
- LE=0 for 3 cycles while ID_annul=1 and PC=12 -> PC, nPC, ID_annul, fetch_count frozen. Resume on LE=1 with the identical sequence.
- nPC=0xFFFFFFFC, no transfer -> nPC wraps to 0. Then R=1 with LE=0 -> PC=0, nPC=4, ID_annul=0, fetch_count=0 on that edge. ID_target=0x43 taken -> nPC=0x40.
